wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_rr_arb.sv | 37 +++
 rtl/wb_stage.sv | 102 ++++++++++
 tb/tb_wb_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths, result-entry type and arbiter pointer encoding for the writeback stage.
package wb_pkg;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_sel_e;

endpackage

// File: rtl/wb_rr_arb.sv
// Two-request round-robin arbiter; req[0]/gnt[0] = ALU, req[1]/gnt[1] = LSU.
module wb_rr_arb
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_sel_e rr_q;
    rr_sel_e rr_d;

    // The pointer only advances when both channels compete.
    always_comb begin
        gnt  = '0;
        rr_d = rr_q;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                gnt  = (rr_q == RR_LSU) ? 2'b10 : 2'b01;
                rr_d = (rr_q == RR_ALU) ? RR_LSU : RR_ALU;
            end
            default: gnt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= RR_ALU;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU/LSU results into a one-entry staging register driving the regfile.
// Optional macro WB_BYPASS_EN adds read-address bypass from the staged write.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN = wb_pkg::XLEN,
    parameter int AW   = wb_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            we,
    output logic [AW-1:0]   waddr,
    output logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic            byp1_hit,
    output logic [XLEN-1:0] byp1_data,
    output logic            byp2_hit,
    output logic [XLEN-1:0] byp2_data,
    output logic [31:0]     wb_count
);

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            stg_v_q,    stg_v_d;
    logic [AW-1:0]   stg_rd_q,   stg_rd_d;
    logic [XLEN-1:0] stg_data_q, stg_data_d;
    logic [31:0]     wb_count_q, wb_count_d;

    // Requests are masked during reset so neither ready can rise.
    assign req = {lsu_valid, alu_valid} & {2{~rst}};

    wb_rr_arb u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign alu_ready = gnt[0];
    assign lsu_ready = gnt[1];

    always_comb begin
        stg_v_d    = |gnt;
        stg_rd_d   = stg_rd_q;
        stg_data_d = stg_data_q;
        if (gnt[0]) begin
            stg_rd_d   = alu_rd;
            stg_data_d = alu_data;
        end else if (gnt[1]) begin
            stg_rd_d   = lsu_rd;
            stg_data_d = lsu_data;
        end
    end

    assign we    = stg_v_q && (stg_rd_q != '0);
    assign waddr = stg_rd_q;
    assign wdata = stg_data_q;

    always_comb begin
        wb_count_d = wb_count_q + {31'd0, we};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_v_q    <= 1'b0;
            stg_rd_q   <= '0;
            stg_data_q <= '0;
            wb_count_q <= '0;
        end else begin
            stg_v_q    <= stg_v_d;
            stg_rd_q   <= stg_rd_d;
            stg_data_q <= stg_data_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count = wb_count_q;

`ifdef WB_BYPASS_EN
    assign byp1_hit  = we && (raddr1 == waddr);
    assign byp2_hit  = we && (raddr2 == waddr);
    assign byp1_data = byp1_hit ? wdata : '0;
    assign byp2_data = byp2_hit ? wdata : '0;
`else
    logic unused_raddr;
    assign unused_raddr = ^{raddr1, raddr2};
    assign byp1_hit  = 1'b0;
    assign byp2_hit  = 1'b0;
    assign byp1_data = '0;
    assign byp2_data = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; bypass expectations follow WB_BYPASS_EN.
module tb_wb_stage;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid, alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid, lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   raddr1, raddr2;
    logic            byp1_hit, byp2_hit;
    logic [XLEN-1:0] byp1_data, byp2_data;
    logic [31:0]     wb_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .byp1_hit  (byp1_hit),
        .byp1_data (byp1_data),
        .byp2_hit  (byp2_hit),
        .byp2_data (byp2_data),
        .wb_count  (wb_count)
    );

    task automatic test_reset();
        rst = 1'b1; alu_valid = 1'b1; lsu_valid = 1'b1;
        alu_rd = 5'd1; alu_data = 64'd1; lsu_rd = 5'd2; lsu_data = 64'd2;
        raddr1 = '0; raddr2 = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({we, waddr, wdata, wb_count} !== {1'b0, 5'd0, 64'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_state: we=%0b waddr=%0d wdata=%0h cnt=%0d, want all 0", we, waddr, wdata, wb_count);
        end
        n_checks++;
        if ({alu_ready, lsu_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 00", {alu_ready, lsu_ready});
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu_single();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'd4;
        #1;
        n_checks++;
        if ({alu_ready, lsu_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL alu_ready: got %b want 10", {alu_ready, lsu_ready});
        end
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        n_checks++;
        if ({we, waddr, wdata, wb_count} !== {1'b1, 5'd2, 64'd4, 32'd0}) begin
            n_fail++;
            $display("FAIL alu_write: we=%0b waddr=%0d wdata=%0h cnt=%0d, want 1/2/4/0", we, waddr, wdata, wb_count);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({we, wb_count} !== {1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL alu_count: we=%0b cnt=%0d, want 0/1", we, wb_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_addr [4];
        logic [1:0]    exp_rdy  [4];
        exp_addr[0] = 5'd4; exp_addr[1] = 5'd3; exp_addr[2] = 5'd4; exp_addr[3] = 5'd3;
        exp_rdy[0]  = 2'b10; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b10; exp_rdy[3] = 2'b01;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'd9;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 64'd11;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({alu_ready, lsu_ready} !== exp_rdy[i]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b want %b", i, {alu_ready, lsu_ready}, exp_rdy[i]);
            end
            @(negedge clk);
            if (i == 3) begin
                alu_valid = 1'b0; lsu_valid = 1'b0;
            end
            #1;
            n_checks++;
            if ({we, waddr, wdata} !== {1'b1, exp_addr[i], (exp_addr[i] == 5'd4) ? 64'd9 : 64'd11}) begin
                n_fail++;
                $display("FAIL b2b_write[%0d]: we=%0b waddr=%0d wdata=%0d, want waddr %0d", i, we, waddr, wdata, exp_addr[i]);
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({we, wb_count} !== {1'b0, 32'd5}) begin
            n_fail++;
            $display("FAIL b2b_count: we=%0b cnt=%0d, want 0/5", we, wb_count);
        end
    endtask

    task automatic test_x0();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'hFF;
        #1;
        n_checks++;
        if (lsu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_ready: got %b want 1", lsu_ready);
        end
        @(negedge clk);
        lsu_valid = 1'b0;
        #1;
        n_checks++;
        if ({we, wb_count} !== {1'b0, 32'd5}) begin
            n_fail++;
            $display("FAIL x0_nowrite: we=%0b cnt=%0d, want 0/5", we, wb_count);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (wb_count !== 32'd5) begin
            n_fail++;
            $display("FAIL x0_count: got %0d want 5", wb_count);
        end
    endtask

    task automatic test_bypass();
        logic            e1_hit, e2_hit;
        logic [XLEN-1:0] e1_data;
`ifdef WB_BYPASS_EN
        e1_hit = 1'b1; e1_data = 64'd11;
`else
        e1_hit = 1'b0; e1_data = 64'd0;
`endif
        e2_hit = 1'b0;
        raddr1 = 5'd3; raddr2 = 5'd4;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'd11;
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        n_checks++;
        if ({byp1_hit, byp1_data} !== {e1_hit, e1_data}) begin
            n_fail++;
            $display("FAIL byp1: hit=%0b data=%0d, want %0b/%0d", byp1_hit, byp1_data, e1_hit, e1_data);
        end
        n_checks++;
        if ({byp2_hit, byp2_data} !== {e2_hit, 64'd0}) begin
            n_fail++;
            $display("FAIL byp2: hit=%0b data=%0d, want 0/0", byp2_hit, byp2_data);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (byp1_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL byp1_idle: got %0b want 0", byp1_hit);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_we5;
        saw_we5 = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'd55;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({alu_ready, lsu_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_ready: got %b want 00", {alu_ready, lsu_ready});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) begin
                rst = 1'b0; alu_valid = 1'b0;
            end
            #1;
            if (we && waddr == 5'd5) saw_we5 = 1'b1;
        end
        n_checks++;
        if (saw_we5 !== 1'b0 || wb_count !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_discard: saw_we5=%0b cnt=%0d, want 0/0", saw_we5, wb_count);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_cnt [3];
        exp_cnt[0] = 32'hFFFF_FFFE; exp_cnt[1] = 32'hFFFF_FFFF; exp_cnt[2] = 32'h0;
        force dut.wb_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.wb_count_q;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'd77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({we, wb_count} !== {1'b1, exp_cnt[i]}) begin
                n_fail++;
                $display("FAIL wrap[%0d]: we=%0b cnt=%0h, want 1/%0h", i, we, wb_count, exp_cnt[i]);
            end
        end
        alu_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_back_to_back();
        test_x0();
        test_bypass();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
